// File: rtl/shift_right_iterative.sv
// Iterative right shifter: one bit per clock, logical or arithmetic fill.
// An accepted request loads the operand, shift count and fill bit; the unit
// then walks the operand right one position per edge until the count reaches
// zero, spends one more edge confirming completion, and pulses done_o.
module shift_right_iterative #(
  parameter int WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic [WIDTH-1:0]         value_i,
  input  logic [$clog2(WIDTH)-1:0] shamt_i,
  input  logic                     arith_i,
  input  logic                     flush_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [WIDTH-1:0]         value_o
);

  localparam int SHAMT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [SHAMT_W-1:0]   r_count;
  logic                 r_fill;
  logic [WIDTH-1:0]     r_value;
  logic                 w_accept;
  logic                 w_count_zero;
  logic                 w_do_shift;

  // A new request is taken only when no operation is in flight; flush wins.
  assign w_accept     = start_i && !flush_i && (r_state != S_SHIFT);
  assign w_count_zero = (r_count == '0);
  assign w_do_shift   = !flush_i && (r_state == S_SHIFT) && !w_count_zero;

  // State register; reset drops any operation in flight.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: flush forces IDLE from anywhere, DONE may chain
  // straight into another SHIFT when a request arrives in that cycle.
  // NOTE: the default assignment at the top keeps this block latch-free
  // even if a branch below forgets to assign w_next_state.
  always_comb begin
    w_next_state = r_state;
    if (flush_i) begin
      w_next_state = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:  if (w_accept) w_next_state = S_SHIFT;
        S_SHIFT: if (w_count_zero) w_next_state = S_DONE;
        S_DONE:  w_next_state = w_accept ? S_SHIFT : S_IDLE;
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  // Output decode straight from the state register, so neither flag has a
  // combinational path from any input.
  always_comb begin
    busy_o = (r_state == S_SHIFT);
    done_o = (r_state == S_DONE);
  end

  // Datapath: load on accept, otherwise shift one bit per edge while the
  // count is non-zero. The fill bit is frozen at accept so later changes to
  // arith_i or to the shifting value cannot alter the sign extension.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_value <= '0;
      r_count <= '0;
      r_fill  <= 1'b0;
    end else if (w_accept) begin
      r_value <= value_i;
      r_count <= shamt_i;
      r_fill  <= arith_i & value_i[WIDTH-1];
    end else if (w_do_shift) begin
      r_value <= {r_fill, r_value[WIDTH-1:1]};
      r_count <= r_count - 1'b1;
    end
  end

  assign value_o = r_value;

endmodule

// File: tb/tb_shift_right_iterative.sv
// Self-checking bench for shift_right_iterative (WIDTH = 32).
// Expected results and completion edges are queued when a request is
// accepted and compared when done_o is observed.
module tb_shift_right_iterative;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic [31:0] value_i;
  logic [4:0]  shamt_i;
  logic        arith_i;
  logic        flush_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] value_o;

  int checks   = 0;
  int failures = 0;
  int edge_cnt = 0;
  int busy_run = 0;

  typedef struct {
    logic [31:0] val;
    int          cyc;
    int          busy;
  } exp_t;

  exp_t exp_q[$];

  shift_right_iterative #(.WIDTH(32)) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .start_i (start_i),
    .value_i (value_i),
    .shamt_i (shamt_i),
    .arith_i (arith_i),
    .flush_i (flush_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .value_o (value_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) edge_cnt <= edge_cnt + 1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] v, input int sh, input logic ar);
    if (ar) return 32'($signed(v) >>> sh);
    return v >> sh;
  endfunction

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      check("busy_done_excl", 64'(busy_o & done_o), 64'd0);
      if (busy_o) busy_run++;
      if (done_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("result", 64'(value_o), 64'(e.val));
          check("done_edge", 64'(edge_cnt), 64'(e.cyc));
          check("busy_cycles", 64'(busy_run), 64'(e.busy));
        end
        busy_run = 0;
      end else if (!busy_o) begin
        busy_run = 0;
      end
    end else begin
      busy_run = 0;
    end
  end

  // Drive one request and let it be accepted on the next rising edge.
  task automatic start_op(input logic [31:0] v, input int sh, input logic ar, input bit expect_done);
    exp_t e;
    start_i = 1'b1;
    value_i = v;
    shamt_i = 5'(sh);
    arith_i = ar;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    value_i = $urandom;
    shamt_i = 5'($urandom);
    arith_i = 1'($urandom);
    check("accept_busy", 64'(busy_o), 64'd1);
    if (expect_done) begin
      e.val  = model(v, sh, ar);
      e.cyc  = edge_cnt + sh + 1;
      e.busy = sh + 1;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
  endtask

  initial begin
    rst_ni  = 1'b0;
    start_i = 1'b0;
    value_i = '0;
    shamt_i = '0;
    arith_i = 1'b0;
    flush_i = 1'b0;
    #1;
    check("rst_value", 64'(value_o), 64'd0);
    check("rst_busy",  64'(busy_o),  64'd0);
    check("rst_done",  64'(done_o),  64'd0);
    #12 rst_ni = 1'b1;

    // First edge after reset release accepts: logical then arithmetic shift by 4.
    start_op(32'h8000_0000, 4, 1'b0, 1'b1);
    wait_drain(50);
    start_op(32'h8000_0000, 4, 1'b1, 1'b1);
    wait_drain(50);

    // shamt 0, then shamt 31 arithmetic with ignored start pulses while busy.
    start_op(32'h1234_5678, 0, 1'b0, 1'b1);
    wait_drain(50);
    start_op(32'h8000_0001, 31, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      start_i = 1'b1;
      value_i = 32'h0000_0000;
      shamt_i = 5'd0;
      arith_i = 1'b0;
      @(posedge clk_i);
      #1;
    end
    start_i = 1'b0;
    wait_drain(100);

    // Back-to-back: second request accepted during the DONE cycle.
    @(negedge clk_i);
    start_op(32'h0000_00F0, 4, 1'b0, 1'b1);
    repeat (5) @(posedge clk_i);
    #1;
    check("done_before_chain", 64'(done_o), 64'd1);
    start_op(32'hFFFF_0000, 16, 1'b0, 1'b1);
    wait_drain(100);

    // Asynchronous reset at count 3 of shamt 10.
    @(negedge clk_i);
    start_op(32'hA5A5_0000, 10, 1'b1, 1'b0);
    repeat (7) @(posedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    check("async_rst_value", 64'(value_o), 64'd0);
    check("async_rst_busy",  64'(busy_o),  64'd0);
    check("async_rst_done",  64'(done_o),  64'd0);
    #10 rst_ni = 1'b1;
    repeat (20) @(negedge clk_i);
    check("post_rst_value", 64'(value_o), 64'd0);
    check("post_rst_busy",  64'(busy_o),  64'd0);

    // Flush at count 3 of shamt 10, with a competing start on the same edge.
    start_op(32'hA5A5_0000, 10, 1'b1, 1'b0);
    repeat (7) @(posedge clk_i);
    #1;
    flush_i = 1'b1;
    start_i = 1'b1;
    value_i = 32'h0000_0001;
    shamt_i = 5'd2;
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
    start_i = 1'b0;
    check("flush_busy",  64'(busy_o),  64'd0);
    check("flush_done",  64'(done_o),  64'd0);
    check("flush_value", 64'(value_o), 64'(model(32'hA5A5_0000, 7, 1'b1)));
    repeat (5) @(negedge clk_i);
    check("flush_hold", 64'(value_o), 64'(model(32'hA5A5_0000, 7, 1'b1)));

    // Random operands, shift amounts and modes.
    for (int i = 0; i < 8; i++) begin
      start_op($urandom, int'($urandom_range(0, 31)), 1'($urandom), 1'b1);
      wait_drain(100);
    end

    repeat (3) @(negedge clk_i);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
